ser6_sched: RTL and testbench
=============================

Name: ser6_sched

Overview:
- Round-robin scheduler that shares one 6-bit parallel-in/serial-out serializer among NREQ requesters.
- Accepts one word per frame from the granted requester via valid/ready.
- Loads the word into an internal shift register and shifts it out LSB-first on a single serial line, with frame-start and valid markers.
- Sits between the parallel word sources and the serial link; replaces the free-running load counter with demand-driven sequencing.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 6, bits per word/frame.
- IDW, $clog2(NREQ), width of grant index (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has a word pending
- req_data  in  NREQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot; word i accepted this cycle when req_valid[i] & req_ready[i]
- dout  out  1  serial data, LSB first
- dout_valid  out  1  dout carries a frame bit this cycle
- frame_start  out  1  high on the first bit of each frame
- gnt_id  out  IDW  index of requester owning the current frame
- busy  out  1  a frame is being shifted

Behaviour:
- Reset (rst=1 at clk edge) sets these values; applies mid-frame, and the partial frame is abandoned without completion:
  - state IDLE, bit_cnt 0, rr_ptr 0, shift register 0;
  - dout 0, dout_valid 0, frame_start 0, gnt_id 0, busy 0;
  - req_ready all 0 (combinationally forced while rst=1).
- States: IDLE, SHIFT (plus PARITY with the option enabled).
- Accept slot: cycle where state==IDLE, or state==SHIFT with bit_cnt==WIDTH-1 (last bit of the frame, or the PARITY cycle when enabled).
- Arbitration is combinational in the accept slot:
  - Winner is the first asserted req_valid scanning from rr_ptr upward, modulo NREQ.
  - req_ready = onehot(winner) in the slot; 0 otherwise.
- On accept edge:
  - shift register <= req_data[winner];
  - gnt_id <= winner;
  - rr_ptr <= (winner+1) mod NREQ;
  - state <= SHIFT, bit_cnt <= 0.
- Latency: first bit appears the cycle after accept.
- Back-to-back frames have zero idle cycles.
- SHIFT, each cycle:
  - dout = sreg[0], dout_valid=1, busy=1.
  - frame_start=1 only when bit_cnt==0.
  - Shift right by one, bit_cnt++.
- After bit WIDTH-1 with no accept: state IDLE, dout_valid 0, dout 0, busy 0. gnt_id holds its last value.
- No request in the slot: no grant, rr_ptr unchanged.
- Requesters must hold req_valid and req_data stable until ready; data is sampled only on the accept edge. Dropping req_valid before ready is legal (request withdrawn).
- rr_ptr advances only on a grant. A single continuous requester gets every frame; others are never starved beyond NREQ-1 frames.

Optional Feature:
- Macro: SER6_PARITY_EN.
- Defined:
  - After data bit WIDTH-1, state PARITY for one cycle: dout = even parity (XOR of the accepted word), dout_valid=1, busy=1, frame_start=0.
  - The accept slot moves from the last data bit to the PARITY cycle.
  - Frame length WIDTH+1.
- Undefined: no PARITY state; frame length WIDTH.

Decomposition:
- Shared package ser6_pkg holds:
  - state enum (IDLE, SHIFT, PARITY);
  - default WIDTH and NREQ constants;
  - function for frame length.
- One natural sub-module: ser6_rr_arb (combinational round-robin pick from req_valid and rr_ptr, outputs one-hot and index).
- Shift register and FSM stay in ser6_sched.

Test Plan:
- Reset, then req_valid=0001, data0=6'b101101 -> ready[0] one cycle.
  - Next 6 cycles: dout 1,0,1,1,0,1, dout_valid=1, frame_start only on the first cycle, gnt_id=0.
  - Then idle: dout_valid=0.
- Requester 2 held valid with words 6'h15 then 6'h2A -> second accept on the last bit of the first frame; 12 contiguous dout_valid cycles, frame_start at cycles 1 and 7.
- All four valid continuously from reset -> grant order 0,1,2,3,0,1…; each ready pulse is exactly one cycle, at frame boundaries.
- rst asserted at bit 3 of a frame -> next cycle all outputs 0, state IDLE, rr_ptr 0.
  - Pending requester 1 wins the next slot.
- Withdraw: req_valid[3] pulses high only during a non-slot cycle -> never granted; rr_ptr unchanged.
- SER6_PARITY_EN defined, word 6'b000111 -> 6 data bits then parity bit 1; 7-cycle frames; back-to-back accept occurs on the parity cycle.

Source files
------------

// File: rtl/ser6_pkg.sv
// ser6_pkg: shared definitions for the ser6 round-robin serializer.
//   - state_e    : FSM states (PARITY is used only when SER6_PARITY_EN is defined)
//   - NREQ_DEF   : default requester count
//   - WIDTH_DEF  : default word width
//   - frame_len(): serial frame length in bits for a given word width
// Optional feature macro: SER6_PARITY_EN (appends an even-parity bit per frame).
package ser6_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    // Number of serial bit-times one frame occupies.
    function automatic int frame_len(input int width);
`ifdef SER6_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/ser6_rr_arb.sv
// ser6_rr_arb: combinational round-robin pick.
//   req    in  NREQ  pending requests
//   ptr    in  IDW   highest-priority index for this pick
//   onehot out NREQ  one-hot winner (0 when nothing requested)
//   idx    out IDW   winner index (0 when nothing requested)
//   any    out 1     some request was found
module ser6_rr_arb
    import ser6_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW-1:0] cand_s;
    logic           hit_s;

    // Scan from ptr upward (wrapping at NREQ); the first pending request wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s         = IDW'((int'(ptr) + k) % NREQ);
            hit_s          = !any && req[cand_s];
            onehot[cand_s] = onehot[cand_s] | hit_s;
            idx            = hit_s ? cand_s : idx;
            any            = any | hit_s;
        end
    end

endmodule

// File: rtl/ser6_sched.sv
// ser6_sched: round-robin scheduler sharing one WIDTH-bit PISO serializer
// among NREQ requesters. A word is accepted from the winner in the accept
// slot (idle, or the last bit-time of the running frame) and shifted out
// LSB-first starting the next cycle, so back-to-back frames have no gap.
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : per-requester word pending
//   req_data     : word i at [i*WIDTH +: WIDTH]
//   req_ready    : one-hot accept strobe (forced 0 during rst)
//   dout         : serial data, LSB first
//   dout_valid   : dout carries a frame bit
//   frame_start  : first bit of a frame
//   gnt_id       : owner of the current/last frame
//   busy         : a frame is being shifted
// Optional feature macro: SER6_PARITY_EN adds a trailing even-parity bit;
// the accept slot then moves to that parity cycle.
module ser6_sched
    import ser6_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  dout,
    output logic                  dout_valid,
    output logic                  frame_start,
    output logic [IDW-1:0]        gnt_id,
    output logic                  busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
`ifdef SER6_PARITY_EN
    logic             par_q, par_d;
`endif

    logic [NREQ-1:0]  win_onehot_s;
    logic [IDW-1:0]   win_idx_s;
    logic             win_any_s;
    logic             slot_s;
    logic             accept_s;
    logic [WIDTH-1:0] word_s;

    ser6_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .onehot (win_onehot_s),
        .idx    (win_idx_s),
        .any    (win_any_s)
    );

    // Accept slot, accept strobe and winner word selection.
    always_comb begin
`ifdef SER6_PARITY_EN
        slot_s = (state_q == ST_IDLE) || (state_q == ST_PARITY);
`else
        slot_s = (state_q == ST_IDLE) ||
                 ((state_q == ST_SHIFT) && (bit_cnt_q == CW'(WIDTH - 1)));
`endif
        accept_s  = slot_s && win_any_s && !rst;
        req_ready = accept_s ? win_onehot_s : '0;
        word_s    = '0;
        for (int i = 0; i < NREQ; i++) begin
            word_s = word_s | (win_onehot_s[i] ? req_data[i*WIDTH +: WIDTH] : '0);
        end
    end

    // Next-state: a grant always (re)starts a frame, otherwise advance the shifter.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        sreg_d    = sreg_q;
        gnt_d     = gnt_q;
`ifdef SER6_PARITY_EN
        par_d     = par_q;
`endif
        if (accept_s) begin
            sreg_d    = word_s;
            gnt_d     = win_idx_s;
            rr_ptr_d  = (win_idx_s == IDW'(NREQ - 1)) ? '0 : win_idx_s + IDW'(1);
            state_d   = ST_SHIFT;
            bit_cnt_d = '0;
`ifdef SER6_PARITY_EN
            par_d     = ^word_s;
`endif
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    sreg_d = sreg_q >> 1;
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
`ifdef SER6_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_IDLE;
`endif
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
                ST_PARITY: state_d = ST_IDLE;
                ST_IDLE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // State register; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            rr_ptr_q  <= '0;
            sreg_q    <= '0;
            gnt_q     <= '0;
`ifdef SER6_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            sreg_q    <= sreg_d;
            gnt_q     <= gnt_d;
`ifdef SER6_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // Serial outputs decoded purely from registered state.
    always_comb begin
        dout        = 1'b0;
        dout_valid  = 1'b0;
        frame_start = 1'b0;
        busy        = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                dout        = sreg_q[0];
                dout_valid  = 1'b1;
                busy        = 1'b1;
                frame_start = (bit_cnt_q == '0);
            end
            ST_PARITY: begin
`ifdef SER6_PARITY_EN
                dout       = par_q;
                dout_valid = 1'b1;
                busy       = 1'b1;
`endif
            end
            default: begin
                dout = 1'b0;
            end
        endcase
        gnt_id = gnt_q;
    end

endmodule

// File: tb/tb_ser6_sched.sv
// Self-checking bench for ser6_sched: directed scenarios with literal
// expectations, then randomized traffic checked against a bit-queue model.
module tb_ser6_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 6;
`ifdef SER6_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  dout, dout_valid, frame_start, busy;
    logic [1:0]            gnt_id;

    ser6_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .gnt_id      (gnt_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: queue of pending serial bits -------------
    typedef struct { bit b; bit fs; } fbit_t;
    fbit_t          mq[$];
    int             m_rr = 0;
    int             m_gnt = 0;
    int             m_win;
    int             m_idx;
    bit             m_on = 1'b0;
    logic [WIDTH-1:0] m_word;
    logic [NREQ-1:0]  m_ready;

    always @(negedge clk) begin
        // A frame may be accepted when at most its final bit remains in flight.
        m_win = -1;
        if (!rst && mq.size() <= 1) begin
            for (int k = 0; k < NREQ; k++) begin
                m_idx = (m_rr + k) % NREQ;
                if (m_win < 0 && req_valid[m_idx]) m_win = m_idx;
            end
        end
        m_ready = '0;
        if (m_win >= 0) m_ready[m_win] = 1'b1;
        if (m_on) begin
            chk("m_ready",  32'(req_ready),   32'(m_ready));
            chk("m_dv",     32'(dout_valid),  32'(mq.size() > 0));
            chk("m_busy",   32'(busy),        32'(mq.size() > 0));
            chk("m_dout",   32'(dout),        (mq.size() > 0) ? 32'(mq[0].b) : 32'd0);
            chk("m_fs",     32'(frame_start), (mq.size() > 0) ? 32'(mq[0].fs) : 32'd0);
            chk("m_gnt",    32'(gnt_id),      32'(m_gnt));
        end
        if (rst) begin
            mq.delete();
            m_rr  = 0;
            m_gnt = 0;
            m_on  = 1'b1;
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (m_win >= 0) begin
                m_word = req_data[m_win*WIDTH +: WIDTH];
                for (int i = 0; i < WIDTH; i++) mq.push_back('{m_word[i], i == 0});
`ifdef SER6_PARITY_EN
                mq.push_back('{^m_word, 1'b0});
`endif
                m_gnt = m_win;
                m_rr  = (m_win + 1) % NREQ;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [NREQ-1:0] obs_ready;
    logic            obs_dout, obs_dv, obs_fs, obs_busy;
    logic [1:0]      obs_gnt;

    // Sample outputs mid-cycle, then return just after the next rising edge.
    task automatic step();
        @(negedge clk);
        obs_ready = req_ready;
        obs_dout  = dout;
        obs_dv    = dout_valid;
        obs_fs    = frame_start;
        obs_busy  = busy;
        obs_gnt   = gnt_id;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] bits;
    logic [15:0] fsmask;
    int          fsn, dvn, seen, seen_at, gcnt;
    int          glist[8];
    int          gpos[8];
    bit          r3_seen;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        repeat (3) step();
        chk("rst_dv",    32'(obs_dv),    32'd0);
        chk("rst_busy",  32'(obs_busy),  32'd0);
        chk("rst_ready", 32'(obs_ready), 32'd0);
        chk("rst_gnt",   32'(obs_gnt),   32'd0);

        // Single frame from requester 0.
        rst = 1'b0;
        req_valid = 4'b0001;
        req_data[5:0] = 6'b101101;
        step();
        chk("d1_ready", 32'(obs_ready), 32'h1);
        req_valid = '0;
        bits = '0;
        fsn = 0;
        for (int i = 0; i < FL; i++) begin
            step();
            bits[i] = obs_dout;
            fsn += int'(obs_fs);
            chk("d1_dv", 32'(obs_dv), 32'd1);
            chk("d1_fs", 32'(obs_fs), (i == 0) ? 32'd1 : 32'd0);
            chk("d1_gnt", 32'(obs_gnt), 32'd0);
        end
        chk("d1_bits", 32'(bits[5:0]), 32'h2D);
`ifdef SER6_PARITY_EN
        chk("d1_par", 32'(bits[6]), 32'd0);
`endif
        step();
        chk("d1_idle_dv", 32'(obs_dv), 32'd0);
        chk("d1_idle_busy", 32'(obs_busy), 32'd0);

        // Requester 2, two words back-to-back.
        req_valid = 4'b0100;
        req_data[17:12] = 6'h15;
        step();
        chk("d2_ready", 32'(obs_ready), 32'h4);
        req_data[17:12] = 6'h2A;
        bits = '0; fsmask = '0; dvn = 0; seen = 0; seen_at = -1;
        for (int i = 0; i < 2*FL; i++) begin
            step();
            bits[i] = obs_dout;
            dvn += int'(obs_dv);
            fsmask[i] = obs_fs;
            if (obs_ready[2]) begin
                seen++;
                seen_at = i;
                req_valid = '0;
            end
        end
        chk("d2_seen", 32'(seen), 32'd1);
        chk("d2_seen_at", 32'(seen_at), 32'(FL - 1));
        chk("d2_dvn", 32'(dvn), 32'(2*FL));
        chk("d2_fsmask", 32'(fsmask), 32'(1) | (32'd1 << FL));
`ifdef SER6_PARITY_EN
        chk("d2_bits", 32'(bits), 32'h3555);
`else
        chk("d2_bits", 32'(bits), 32'h0A95);
`endif
        step();
        chk("d2_idle_dv", 32'(obs_dv), 32'd0);

        // All four requesters continuously valid from reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b1111;
        req_data = 24'hA5C3_96;
        gcnt = 0;
        for (int i = 0; i <= 6*FL; i++) begin
            step();
            if (obs_ready != '0) begin
                chk("d3_onehot", 32'($countones(obs_ready)), 32'd1);
                if (gcnt < 8) begin
                    for (int r = 0; r < NREQ; r++) if (obs_ready[r]) glist[gcnt] = r;
                    gpos[gcnt] = i;
                end
                gcnt++;
            end
        end
        chk("d3_gcnt", 32'(gcnt), 32'd7);
        for (int k = 0; k < 6; k++) begin
            chk("d3_order", 32'(glist[k]), 32'(k % 4));
            chk("d3_pos", 32'(gpos[k]), 32'(k * FL));
        end

        // Reset during bit 3, requester 1 pending.
        repeat (3) step();
        rst = 1'b1;
        req_valid = 4'b0010;
        step();
        chk("d4_bit3_dv", 32'(obs_dv), 32'd1);
        chk("d4_rst_ready", 32'(obs_ready), 32'd0);
        step();
        chk("d4_dv", 32'(obs_dv), 32'd0);
        chk("d4_busy", 32'(obs_busy), 32'd0);
        chk("d4_dout", 32'(obs_dout), 32'd0);
        chk("d4_fs", 32'(obs_fs), 32'd0);
        chk("d4_gnt", 32'(obs_gnt), 32'd0);
        rst = 1'b0;
        step();
        chk("d4_win1", 32'(obs_ready), 32'h2);
        req_valid = '0;
        step();
        chk("d4_gnt1", 32'(obs_gnt), 32'd1);
        chk("d4_fs1", 32'(obs_fs), 32'd1);

        // Withdraw: requester 3 valid for one non-slot cycle only.
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        r3_seen = obs_ready[3];
        for (int i = 0; i < FL; i++) begin
            step();
            r3_seen = r3_seen | obs_ready[3];
        end
        chk("d5_no_r3", 32'(r3_seen), 32'd0);
        req_valid = 4'b1101;
        step();
        chk("d5_rr_kept", 32'(obs_ready), 32'h4);
        req_valid = '0;

        // Randomized traffic with occasional withdrawals and resets.
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (req_valid[r] && obs_ready[r]) begin
                    req_valid[r] = 1'($urandom_range(0, 1));
                    req_data[r*WIDTH +: WIDTH] = WIDTH'($urandom);
                end else if (req_valid[r]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[r] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_valid[r] = 1'b1;
                    req_data[r*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        req_valid = '0;
        repeat (2*FL) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
